// File: rtl/can_periodic_tx.sv
// Periodic CAN transmit scheduler: N_CH free-running period counters feed sticky pending flags,
// which a round-robin arbiter drains into a single registered output word. Option: CAN_PERIODIC_TX_OVERRUN_EN.
module can_periodic_tx #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 20,
    parameter int unsigned SEQ_W = 28
) (
    input  logic                    can1_clk,
    input  logic                    can1_rstn,
    input  logic [N_CH-1:0]         ch_en_i,
    input  logic [N_CH*CNT_W-1:0]   cfg_period_i,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic [31:0]             tx_data_o,
    output logic [15:0]             overrun_cnt_o
);
    localparam int unsigned IDX_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned SUM_W       = IDX_W + 1;
    localparam int unsigned CH_FIELD_W  = 4;
    localparam int unsigned SEQ_FIELD_W = 28;

    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0][SEQ_W-1:0] seq_q, seq_d;
    logic [N_CH-1:0]            pend_q, pend_d;
    logic [IDX_W-1:0]           rr_q, rr_d;
    logic                       tx_valid_q, tx_valid_d;
    logic [31:0]                tx_data_q, tx_data_d;

    logic [N_CH-1:0]            active;
    logic [N_CH-1:0]            tick;
    logic [N_CH-1:0]            eligible;
    logic [N_CH-1:0]            grant_oh;
    logic [IDX_W-1:0]           grant_idx;
    logic [IDX_W-1:0]           idx;
    logic [SUM_W-1:0]           sum;
    logic                       found;
    logic                       load;

    // Per-channel counter: ticks at P-1, wraps silently if the period shrank below the count
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] period;
        assign period    = cfg_period_i[g*CNT_W +: CNT_W];
        assign active[g] = ch_en_i[g] && (period != '0);
        assign tick[g]   = active[g] && (cnt_q[g] == period - CNT_W'(1));
        assign cnt_d[g]  = (!active[g] || (cnt_q[g] >= period - CNT_W'(1))) ? '0
                                                                            : cnt_q[g] + CNT_W'(1);
    end

    // A disabled channel's stale pending flag must never win arbitration
    assign eligible = pend_q & active;

    // Round-robin search starting at rr_q
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        sum       = '0;
        idx       = '0;
        for (int unsigned off = 0; off < N_CH; off++) begin
            sum = {1'b0, rr_q} + SUM_W'(off);
            if (sum >= SUM_W'(N_CH)) begin
                sum = sum - SUM_W'(N_CH);
            end
            idx = sum[IDX_W-1:0];
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        load = (!tx_valid_q || tx_ready_i) && found;
        if (load) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Output stage, sequence numbers, arbitration pointer and pending flags
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        seq_d      = seq_q;
        rr_d       = rr_q;
        if (load) begin
            tx_valid_d       = 1'b1;
            tx_data_d        = {CH_FIELD_W'(grant_idx), SEQ_FIELD_W'(seq_q[grant_idx])};
            seq_d[grant_idx] = seq_q[grant_idx] + SEQ_W'(1);
            rr_d             = (grant_idx == IDX_W'(N_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
        end else if (tx_ready_i) begin
            tx_valid_d = 1'b0;
        end
        pend_d = (tick | (pend_q & ~grant_oh)) & active;
    end

    always_ff @(posedge can1_clk or negedge can1_rstn) begin
        if (!can1_rstn) begin
            cnt_q      <= '0;
            seq_q      <= '0;
            pend_q     <= '0;
            rr_q       <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            pend_q     <= pend_d;
            rr_q       <= rr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;

`ifdef CAN_PERIODIC_TX_OVERRUN_EN
    logic [N_CH-1:0] ovr_evt;
    logic [16:0]     ovr_sum;
    logic [15:0]     overrun_cnt_q, overrun_cnt_d;

    // Tick that finds its flag still set and not being granted this cycle
    assign ovr_evt = tick & pend_q & ~grant_oh;

    always_comb begin
        ovr_sum       = {1'b0, overrun_cnt_q} + 17'($countones(ovr_evt));
        overrun_cnt_d = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
    end

    always_ff @(posedge can1_clk or negedge can1_rstn) begin
        if (!can1_rstn) begin
            overrun_cnt_q <= '0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign overrun_cnt_o = overrun_cnt_q;
`else
    assign overrun_cnt_o = 16'h0000;
`endif

endmodule
